counter_period_prog: RTL and testbench

//  Runtime-programmable period/compare counter, next generation of the fixed-period counters.

---
 rtl/counter_pkg.sv | 21 ++
 rtl/counter_cfg_shadow.sv | 66 ++++++
 rtl/counter_period_prog.sv | 108 ++++++++++
 tb/tb_counter_period_prog.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared mode encodings, FSM states and configuration legality check for the programmable counter.
package counter_pkg;

    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // Widest counter the legality check supports.
    localparam int CFG_MAX_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A period shorter than 2 cannot produce a distinct wrap, and a compare point past the period never fires.
    function automatic logic cfg_ok(input logic [CFG_MAX_W-1:0] period,
                                    input logic [CFG_MAX_W-1:0] cmp);
        return (period >= CFG_MAX_W'(2)) && (cmp <= period);
    endfunction

endpackage

// File: rtl/counter_cfg_shadow.sv
// Config capture: validates an offered period/compare, holds it pending, and loads the active regs on apply.
// Error pulses one cycle after a rejected offer; ready stays low while a valid config waits for its boundary.
module counter_cfg_shadow
    import counter_pkg::*;
#(
    parameter int p_WIDTH      = 16,
    parameter int p_RST_PERIOD = 4,
    parameter int p_RST_CMP    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    input  logic [p_WIDTH-1:0] cfg_period,
    input  logic [p_WIDTH-1:0] cfg_cmp,
    input  logic               apply_ok,
    output logic               cfg_ready,
    output logic               cfg_err,
    output logic [p_WIDTH-1:0] pm1,
    output logic [p_WIDTH-1:0] cmp,
    output logic [p_WIDTH-1:0] cm1
);

    localparam logic [p_WIDTH-1:0] RST_P   = p_WIDTH'(p_RST_PERIOD);
    localparam logic [p_WIDTH-1:0] RST_PM1 = p_WIDTH'(p_RST_PERIOD - 1);
    localparam logic [p_WIDTH-1:0] RST_C   = p_WIDTH'(p_RST_CMP);
    localparam logic [p_WIDTH-1:0] RST_CM1 = p_WIDTH'(p_RST_CMP - 1);

    logic               pending;
    logic [p_WIDTH-1:0] sh_period;
    logic [p_WIDTH-1:0] sh_cmp;
    logic               accept;
    logic               legal;
    logic               apply;

    assign cfg_ready = !pending;
    assign accept    = cfg_valid && !pending;
    assign legal     = cfg_ok(CFG_MAX_W'(cfg_period), CFG_MAX_W'(cfg_cmp));
    // Pending is registered, so an offer can never be applied in the cycle it is accepted.
    assign apply     = pending && apply_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            sh_period <= RST_P;
            sh_cmp    <= RST_C;
            cfg_err   <= 1'b0;
            pm1       <= RST_PM1;
            cmp       <= RST_C;
            cm1       <= RST_CM1;
        end else begin
            cfg_err <= accept && !legal;
            if (apply) begin
                pm1     <= sh_period - 1'b1;
                cmp     <= sh_cmp;
                cm1     <= sh_cmp - 1'b1;
                pending <= 1'b0;
            end
            if (accept && legal) begin
                sh_period <= cfg_period;
                sh_cmp    <= cfg_cmp;
                pending   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_period_prog.sv
// Programmable period/compare counter with continuous and one-shot modes, compare tick and PWM level.
// Ticks and PWM are same-cycle decodes of the count; new config takes effect the cycle after a period boundary.
module counter_period_prog
    import counter_pkg::*;
#(
    parameter int p_WIDTH      = 16,
    parameter int p_RST_PERIOD = 4,
    parameter int p_RST_CMP    = 2
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_enable,
    input  logic               i_clear,
    input  logic               i_mode,
    input  logic               i_start,
    input  logic               i_cfg_valid,
    output logic               o_cfg_ready,
    input  logic [p_WIDTH-1:0] i_cfg_period,
    input  logic [p_WIDTH-1:0] i_cfg_cmp,
    output logic               o_cfg_err,
    output logic [p_WIDTH-1:0] o_count,
    output logic               o_period,
    output logic               o_cmp,
    output logic               o_pwm,
    output logic               o_busy
);

    state_t             state;
    state_t             state_nxt;
    logic [p_WIDTH-1:0] count;
    logic [p_WIDTH-1:0] pm1;
    logic [p_WIDTH-1:0] cmp;
    logic [p_WIDTH-1:0] cm1;
    logic               run;
    logic               active;
    logic               at_end;
    logic               period_tick;
    logic               apply_ok;

    // Continuous mode counts from the first cycle out of reset, before the state register has reached RUN.
    assign run         = (state == RUN) || (i_mode == MODE_CONT);
    assign active      = run && i_enable && !i_clear;
    assign at_end      = (count == pm1);
    assign period_tick = active && at_end;

    assign o_count  = count;
    assign o_period = period_tick;
    assign o_cmp    = active && (cmp != '0) && (count == cm1);
    assign o_pwm    = active && (count < cmp);
    assign o_busy   = run;

    // Safe points to swap period/compare: boundary, idle, frozen at zero, or being cleared.
    assign apply_ok = period_tick || !run || (!i_enable && (count == '0)) || i_clear;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if ((i_mode == MODE_CONT) || (i_start && !i_clear)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if ((i_mode == MODE_ONESHOT) && (i_clear || period_tick)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (active) begin
            count <= at_end ? '0 : count + 1'b1;
        end
    end

    counter_cfg_shadow #(
        .p_WIDTH      (p_WIDTH),
        .p_RST_PERIOD (p_RST_PERIOD),
        .p_RST_CMP    (p_RST_CMP)
    ) u_cfg_shadow (
        .clk        (i_clk),
        .rst_n      (i_reset_n),
        .cfg_valid  (i_cfg_valid),
        .cfg_period (i_cfg_period),
        .cfg_cmp    (i_cfg_cmp),
        .apply_ok   (apply_ok),
        .cfg_ready  (o_cfg_ready),
        .cfg_err    (o_cfg_err),
        .pm1        (pm1),
        .cmp        (cmp),
        .cm1        (cm1)
    );

endmodule

// File: tb/tb_counter_period_prog.sv
// Bench for counter_period_prog: directed scenarios plus random traffic, scored against a behavioural model.
module tb_counter_period_prog;

    localparam int W = 16;

    logic         i_clk = 1'b0;
    logic         i_reset_n;
    logic         i_enable;
    logic         i_clear;
    logic         i_mode;
    logic         i_start;
    logic         i_cfg_valid;
    logic         o_cfg_ready;
    logic [W-1:0] i_cfg_period;
    logic [W-1:0] i_cfg_cmp;
    logic         o_cfg_err;
    logic [W-1:0] o_count;
    logic         o_period;
    logic         o_cmp;
    logic         o_pwm;
    logic         o_busy;

    typedef struct packed {
        logic [W-1:0] count;
        logic         period;
        logic         cmp;
        logic         pwm;
        logic         busy;
        logic         ready;
        logic         err;
    } obs_t;

    obs_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   mon_cyc = 0;
    bit   cur_mode;

    // Reference model state: current position in the period and the settings in force.
    int   m_cnt;
    int   m_per;
    int   m_cmp;
    int   m_pp;
    int   m_pc;
    bit   m_pend;
    bit   m_shot;
    bit   m_err;

    always #5 i_clk = ~i_clk;

    counter_period_prog #(
        .p_WIDTH      (W),
        .p_RST_PERIOD (4),
        .p_RST_CMP    (2)
    ) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_enable     (i_enable),
        .i_clear      (i_clear),
        .i_mode       (i_mode),
        .i_start      (i_start),
        .i_cfg_valid  (i_cfg_valid),
        .o_cfg_ready  (o_cfg_ready),
        .i_cfg_period (i_cfg_period),
        .i_cfg_cmp    (i_cfg_cmp),
        .o_cfg_err    (o_cfg_err),
        .o_count      (o_count),
        .o_period     (o_period),
        .o_cmp        (o_cmp),
        .o_pwm        (o_pwm),
        .o_busy       (o_busy)
    );

    always @(negedge i_clk) begin
        obs_t e;
        obs_t a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {o_count, o_period, o_cmp, o_pwm, o_busy, o_cfg_ready, o_cfg_err};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs cycle %0d: got cnt=%0d per=%b cmp=%b pwm=%b busy=%b rdy=%b err=%b, want cnt=%0d per=%b cmp=%b pwm=%b busy=%b rdy=%b err=%b",
                         mon_cyc, a.count, a.period, a.cmp, a.pwm, a.busy, a.ready, a.err,
                         e.count, e.period, e.cmp, e.pwm, e.busy, e.ready, e.err);
            end
            mon_cyc++;
        end
    end

    // One clock cycle: drive inputs, predict outputs, advance the model past the edge.
    task automatic step(input bit en, input bit clr, input bit mode, input bit start,
                        input bit cv, input int cp, input int cc);
        bit   busy;
        bit   act;
        bit   last;
        bit   take;
        bit   good;
        bit   apply;
        obs_t e;
        busy     = (mode == 1'b0) || m_shot;
        act      = busy && en && !clr;
        last     = act && (m_cnt == m_per - 1);
        e.count  = W'(m_cnt);
        e.period = last;
        e.cmp    = act && (m_cmp != 0) && (m_cnt == m_cmp - 1);
        e.pwm    = act && (m_cnt < m_cmp);
        e.busy   = busy;
        e.ready  = !m_pend;
        e.err    = m_err;

        i_enable     = en;
        i_clear      = clr;
        i_mode       = mode;
        i_start      = start;
        i_cfg_valid  = cv;
        i_cfg_period = W'(cp);
        i_cfg_cmp    = W'(cc);
        exp_q.push_back(e);

        take  = cv && !m_pend;
        good  = (cp >= 2) && (cc <= cp);
        apply = m_pend && (last || !busy || (!en && m_cnt == 0) || clr);
        m_err = take && !good;
        if (apply) begin
            m_per  = m_pp;
            m_cmp  = m_pc;
            m_pend = 1'b0;
        end
        if (take && good) begin
            m_pend = 1'b1;
            m_pp   = cp;
            m_pc   = cc;
        end
        if (clr || last) m_cnt = 0;
        else if (act)    m_cnt = m_cnt + 1;
        if (clr || last)                  m_shot = 1'b0;
        else if (mode && start && !busy)  m_shot = 1'b1;

        @(posedge i_clk);
        #1;
    endtask

    task automatic run_idle(input int n, input bit en);
        repeat (n) step(en, 1'b0, cur_mode, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset(input bit mode);
        obs_t a;
        obs_t want;
        i_reset_n    = 1'b0;
        i_mode       = 1'b1;
        i_enable     = 1'b0;
        i_clear      = 1'b0;
        i_start      = 1'b0;
        i_cfg_valid  = 1'b0;
        i_cfg_period = '0;
        i_cfg_cmp    = '0;
        #2;
        a    = {o_count, o_period, o_cmp, o_pwm, o_busy, o_cfg_ready, o_cfg_err};
        want = {{W{1'b0}}, 6'b000010};
        checks++;
        if (a !== want) begin
            errors++;
            $display("FAIL reset outputs: got %h want %h", a, want);
        end
        m_cnt  = 0;
        m_per  = 4;
        m_cmp  = 2;
        m_pp   = 0;
        m_pc   = 0;
        m_pend = 1'b0;
        m_shot = 1'b0;
        m_err  = 1'b0;
        @(posedge i_clk);
        #1;
        cur_mode  = mode;
        i_mode    = mode;
        i_reset_n = 1'b1;
    endtask

    initial begin
        // Continuous defaults, P=4 C=2.
        do_reset(1'b0);
        run_idle(12, 1'b1);

        // Reprogram to P=10 C=3 while at count 1.
        run_idle(1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10, 3);
        run_idle(25, 1'b1);

        // Illegal offers are rejected without disturbing the running settings.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0);
        run_idle(2, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10, 11);
        run_idle(12, 1'b1);

        // Freeze for three cycles at count 2.
        for (int k = 0; k < 20 && m_cnt != 2; k++) run_idle(1, 1'b1);
        run_idle(3, 1'b0);
        run_idle(15, 1'b1);

        // Leave a config pending mid-period, then reset asynchronously.
        for (int k = 0; k < 20 && m_cnt != 4; k++) run_idle(1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12, 5);
        run_idle(1, 1'b1);
        do_reset(1'b0);
        run_idle(10, 1'b1);

        // Compare at the period end, then compare of zero.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3, 3);
        run_idle(10, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3, 0);
        run_idle(10, 1'b1);

        // One-shot with P=5; a second start while busy is ignored.
        do_reset(1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5, 2);
        run_idle(2, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        run_idle(2, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        run_idle(6, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        run_idle(2, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        run_idle(4, 1'b1);

        // Random traffic in each mode.
        do_reset(1'b0);
        repeat (1500) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0, 1'b0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
                 int'($urandom_range(0, 12)), int'($urandom_range(0, 13)));
        end
        do_reset(1'b1);
        repeat (1500) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0, 1'b1,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
                 int'($urandom_range(0, 12)), int'($urandom_range(0, 13)));
        end

        run_idle(2, 1'b1);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard drain: got %0d left want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
